keypad_scan_ctrl: RTL and testbench

- Scans a 4x4 matrix keypad: drives one row low at a time, samples the four column inputs, and confirms a single key over several scan periods.
- Emits a 4-bit key code with a one-cycle valid strobe and a held-level flag.
- Sits between the board keypad pins and the user-logic FSMs. It replaces per-pin debouncing for keypad inputs: one shared time base, one confirmation counter.

---
 rtl/keypad_pkg.sv | 32 +++
 rtl/scan_tick_gen.sv | 29 ++
 rtl/keypad_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types, constants and column-sample classifier for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned CODE_W = 4;

  typedef enum logic [1:0] {StScan, StConfirm, StHeld} state_e;

  typedef struct packed {
    logic       single;
    logic [1:0] idx;
  } col_class_t;

  // single is set only when exactly one column is low; idx is the lowest low column.
  function automatic col_class_t classify_col(input logic [COLS-1:0] col);
    col_class_t  res;
    int unsigned n_low;
    res.single = 1'b0;
    res.idx    = '0;
    n_low      = 0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (!col[i]) begin
        n_low++;
        res.idx = 2'(i);
      end
    end
    res.single = (n_low == 1);
    return res;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running prescaler producing a one-cycle tick every SCAN_DIV clocks.
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned    CntW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CntMax);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: rotates an active-low row, synchronizes the columns and
// confirms a single key press/release over DEBOUNCE_SCANS consecutive ticks.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_down
);

  localparam logic [7:0] DebN = 8'(DEBOUNCE_SCANS);

  logic              tick;
  logic [COLS-1:0]   col_meta_q, col_s_q;
  state_e            state_q, state_d;
  logic [1:0]        row_idx_q, row_idx_d;
  logic [7:0]        cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0] cand_q, cand_d, smp_code;
  logic [CODE_W-1:0] key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_down_q, key_down_d;
  col_class_t        smp;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign smp      = classify_col(col_s_q);
  assign smp_code = {row_idx_q, smp.idx};
  assign cnt_inc  = cnt_q + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_meta_q  <= '1;
      col_s_q     <= '1;
      state_q     <= StScan;
      row_idx_q   <= '0;
      cnt_q       <= '0;
      cand_q      <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      col_meta_q  <= col;
      col_s_q     <= col_meta_q;
      state_q     <= state_d;
      row_idx_q   <= row_idx_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  // MULTI samples never count as a key: only smp.single is ever inspected.
  always_comb begin
    state_d     = state_q;
    row_idx_d   = row_idx_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    if (tick) begin
      unique case (state_q)
        StScan: begin
          if (smp.single) begin
            cand_d = smp_code;
            if (DebN == 8'd1) begin
              key_code_d  = smp_code;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              cnt_d       = '0;
              state_d     = StHeld;
            end else begin
              cnt_d   = 8'd1;
              state_d = StConfirm;
            end
          end else begin
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        StConfirm: begin
          if (smp.single && (smp_code == cand_q)) begin
            if (cnt_inc == DebN) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              cnt_d       = '0;
              state_d     = StHeld;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = '0;
            state_d   = StScan;
            row_idx_d = row_idx_q + 2'd1;
          end
        end
        StHeld: begin
          if (smp.single) begin
            cnt_d = '0;
          end else if (cnt_inc == DebN) begin
            key_down_d = 1'b0;
            cnt_d      = '0;
            state_d    = StScan;
            row_idx_d  = row_idx_q + 2'd1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StScan;
      endcase
    end
  end

  always_comb begin
    row       = ~(4'b0001 << row_idx_q);
    key_code  = key_code_q;
    key_valid = key_valid_q;
    key_down  = key_down_q;
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_SCANS=3 and a matrix keypad model.
module tb_keypad_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  col, row, key_code;
  logic        key_valid, key_down;
  logic [15:0] keys = '0;

  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  // A pressed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
      end
    end
  end

  always @(negedge clk) if (key_valid === 1'b1) pulses++;

  keypad_scan_ctrl #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after posedge number n counted from reset release.
  task automatic adv_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      edge_n++;
    end
    #1;
  endtask

  initial begin
    #1 reset = 1'b1;
    #10 reset = 1'b0;
    #1;
    // 1: idle scanning
    check_eq("rst_row", 32'(row), 32'hE);
    check_eq("rst_code", 32'(key_code), 32'h0);
    check_eq("rst_valid", 32'(key_valid), 32'h0);
    check_eq("rst_down", 32'(key_down), 32'h0);
    adv_to(3);  check_eq("row_hold", 32'(row), 32'hE);
    adv_to(4);  check_eq("row1", 32'(row), 32'hD);
    adv_to(8);  check_eq("row2", 32'(row), 32'hB);
    adv_to(12); check_eq("row3", 32'(row), 32'h7);
    adv_to(16); check_eq("row_wrap", 32'(row), 32'hE);
    check_eq("idle_pulses", 32'(pulses), 32'd0);

    // 2: clean press of r2c1
    keys[9] = 1'b1;
    adv_to(28); check_eq("frozen_row", 32'(row), 32'hB);
    adv_to(35); check_eq("pre_valid", 32'(key_valid), 32'h0);
    check_eq("pre_down", 32'(key_down), 32'h0);
    adv_to(36); check_eq("acc_valid", 32'(key_valid), 32'h1);
    check_eq("acc_code", 32'(key_code), 32'h9);
    check_eq("acc_down", 32'(key_down), 32'h1);
    adv_to(37); check_eq("valid_1clk", 32'(key_valid), 32'h0);
    keys[9] = 1'b0;
    adv_to(47); check_eq("rel_down_hold", 32'(key_down), 32'h1);
    adv_to(48); check_eq("rel_down", 32'(key_down), 32'h0);
    check_eq("rel_row", 32'(row), 32'h7);
    check_eq("code_kept", 32'(key_code), 32'h9);
    check_eq("pulses_t2", 32'(pulses), 32'd1);

    // 3: bounce on r2c1, then steady
    keys[9] = 1'b1;
    adv_to(64); keys[9] = 1'b0;
    adv_to(68); check_eq("bounce_row", 32'(row), 32'h7);
    check_eq("bounce_valid", 32'(key_valid), 32'h0);
    keys[9] = 1'b1;
    adv_to(72); keys[9] = 1'b0;
    adv_to(76); keys[9] = 1'b1;
    adv_to(91); check_eq("steady_pre", 32'(key_valid), 32'h0);
    check_eq("bounce_pulses", 32'(pulses), 32'd1);
    adv_to(92); check_eq("steady_valid", 32'(key_valid), 32'h1);
    check_eq("steady_code", 32'(key_code), 32'h9);
    keys[9] = 1'b0;
    adv_to(104); check_eq("steady_rel", 32'(key_down), 32'h0);

    // 4: two keys on row 2 are ignored
    keys[8] = 1'b1;
    keys[9] = 1'b1;
    adv_to(120); check_eq("multi_row3", 32'(row), 32'h7);
    adv_to(124); check_eq("multi_row0", 32'(row), 32'hE);
    check_eq("multi_pulses", 32'(pulses), 32'd2);
    keys = '0;

    // 5: release with a glitch
    keys[9] = 1'b1;
    adv_to(143); check_eq("t5_pre", 32'(key_valid), 32'h0);
    adv_to(144); check_eq("t5_valid", 32'(key_valid), 32'h1);
    keys[9] = 1'b0;
    adv_to(152); keys[9] = 1'b1;
    adv_to(156); keys[9] = 1'b0;
    adv_to(160); check_eq("glitch_down", 32'(key_down), 32'h1);
    adv_to(167); check_eq("glitch_down2", 32'(key_down), 32'h1);
    adv_to(168); check_eq("clean_rel", 32'(key_down), 32'h0);
    check_eq("clean_row", 32'(row), 32'h7);
    check_eq("t5_pulses", 32'(pulses), 32'd3);

    // 6: asynchronous reset while held
    keys[9] = 1'b1;
    adv_to(192); check_eq("t6_valid", 32'(key_valid), 32'h1);
    adv_to(194); check_eq("t6_down", 32'(key_down), 32'h1);
    check_eq("t6_row", 32'(row), 32'hB);
    check_eq("t6_pulses", 32'(pulses), 32'd4);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_down", 32'(key_down), 32'h0);
    check_eq("arst_row", 32'(row), 32'hE);
    check_eq("arst_code", 32'(key_code), 32'h0);
    check_eq("arst_valid", 32'(key_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
